// File: rtl/nabp_swap_control.sv
// Sequencer for the two swappable back-projection units: hands out per-angle
// accumulator parameters, grants lock-step swaps and routes the filling unit's RAM address.
//
//   state | meaning
//   IDLE  | waiting for kick, fr_s_val held at 0
//   RUN   | serving next-iteration and swap requests
//   DONE  | one-cycle sweep-complete pulse
module nabp_swap_control #(
    parameter int pNoOfAngles  = 8,
    parameter int pShWidth     = 12,
    parameter int pMpInitWidth = 12,
    parameter int pMpBaseWidth = 12,
    parameter int pSLength     = 10,
    parameter int pShInit      = 0,
    parameter int pShStep      = 1,
    parameter int pMpInit0     = 0,
    parameter int pMpInitStep  = 1,
    parameter int pMpBase0     = 0,
    parameter int pMpBaseStep  = 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    kick,
    output logic                    done,
    output logic                    busy,
    input  logic                    u0_swap,
    input  logic                    u1_swap,
    input  logic                    u0_next_itr,
    input  logic                    u1_next_itr,
    output logic                    u0_swap_ack,
    output logic                    u1_swap_ack,
    output logic                    u0_next_itr_ack,
    output logic                    u1_next_itr_ack,
    output logic [pShWidth-1:0]     sh_accu_base,
    output logic [pMpInitWidth-1:0] mp_accu_init,
    output logic [pMpBaseWidth-1:0] mp_accu_base,
    input  logic [pSLength-1:0]     u0_s_val,
    input  logic [pSLength-1:0]     u1_s_val,
    output logic [pSLength-1:0]     fr_s_val,
    output logic                    sel
);

    localparam int CW = $clog2(pNoOfAngles + 2);

    localparam logic [CW-1:0] ANG_LAST  = CW'(pNoOfAngles);
    localparam logic [CW-1:0] SWAP_LAST = CW'(pNoOfAngles + 1);

    localparam logic [pShWidth-1:0]     SH_INIT  = pShWidth'(pShInit);
    localparam logic [pShWidth-1:0]     SH_STEP  = pShWidth'(pShStep);
    localparam logic [pMpInitWidth-1:0] MPI_INIT = pMpInitWidth'(pMpInit0);
    localparam logic [pMpInitWidth-1:0] MPI_STEP = pMpInitWidth'(pMpInitStep);
    localparam logic [pMpBaseWidth-1:0] MPB_INIT = pMpBaseWidth'(pMpBase0);
    localparam logic [pMpBaseWidth-1:0] MPB_STEP = pMpBaseWidth'(pMpBaseStep);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]              state;
    logic [1:0]              state_nxt;
    logic [CW-1:0]           angle_cnt;
    logic [CW-1:0]           swap_cnt;
    logic [pShWidth-1:0]     sh_reg;
    logic [pMpInitWidth-1:0] mpi_reg;
    logic [pMpBaseWidth-1:0] mpb_reg;
    logic                    serving;
    logic                    grant0;
    logic                    grant1;
    logic                    grant_swap;

    assign busy = (state != IDLE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (kick) state_nxt = RUN;
            RUN:     if (swap_cnt == SWAP_LAST) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // A unit whose ack is currently high is skipped, so a request still held
    // during its own ack cycle is not granted twice.
    always_comb begin
        serving    = (state == RUN) && (swap_cnt != SWAP_LAST);
        grant0     = serving && (angle_cnt != ANG_LAST) && u0_next_itr && !u0_next_itr_ack;
        grant1     = serving && (angle_cnt != ANG_LAST) && !grant0 && u1_next_itr && !u1_next_itr_ack;
        grant_swap = serving && u0_swap && u1_swap && !u0_swap_ack;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state           <= IDLE;
            done            <= 1'b0;
            u0_swap_ack     <= 1'b0;
            u1_swap_ack     <= 1'b0;
            u0_next_itr_ack <= 1'b0;
            u1_next_itr_ack <= 1'b0;
            sh_accu_base    <= '0;
            mp_accu_init    <= '0;
            mp_accu_base    <= '0;
            fr_s_val        <= '0;
            sel             <= 1'b0;
            angle_cnt       <= '0;
            swap_cnt        <= '0;
            sh_reg          <= SH_INIT;
            mpi_reg         <= MPI_INIT;
            mpb_reg         <= MPB_INIT;
        end else begin
            state           <= state_nxt;
            done            <= (state_nxt == DONE);
            u0_next_itr_ack <= grant0;
            u1_next_itr_ack <= grant1;
            u0_swap_ack     <= grant_swap;
            u1_swap_ack     <= grant_swap;

            if ((state == IDLE) && kick) begin
                sh_reg    <= SH_INIT;
                mpi_reg   <= MPI_INIT;
                mpb_reg   <= MPB_INIT;
                angle_cnt <= '0;
                swap_cnt  <= '0;
                sel       <= 1'b0;
            end

            if (grant0 || grant1) begin
                sh_accu_base <= sh_reg;
                mp_accu_init <= mpi_reg;
                mp_accu_base <= mpb_reg;
                sh_reg       <= sh_reg + SH_STEP;
                mpi_reg      <= mpi_reg + MPI_STEP;
                mpb_reg      <= mpb_reg + MPB_STEP;
                angle_cnt    <= angle_cnt + 1'b1;
            end

            if (grant_swap) begin
                sel      <= ~sel;
                swap_cnt <= swap_cnt + 1'b1;
            end

            if ((state == IDLE) || (state_nxt == IDLE))
                fr_s_val <= '0;
            else
                fr_s_val <= sel ? u1_s_val : u0_s_val;
        end
    end

endmodule

// File: tb/tb_nabp_swap_control.sv
// Scoreboard bench for nabp_swap_control: stimulus queues expected grants,
// a negedge monitor pops and compares them as the DUT raises acks and done.
module tb_nabp_swap_control;

    localparam int N = 4;

    logic        clk;
    logic        reset_n;
    logic        kick;
    logic        done;
    logic        busy;
    logic        u0_swap, u1_swap;
    logic        u0_next_itr, u1_next_itr;
    logic        u0_swap_ack, u1_swap_ack;
    logic        u0_next_itr_ack, u1_next_itr_ack;
    logic [11:0] sh_accu_base, mp_accu_init, mp_accu_base;
    logic [9:0]  u0_s_val, u1_s_val, fr_s_val;
    logic        sel;

    nabp_swap_control #(
        .pNoOfAngles(N),
        .pShStep(1),
        .pMpInitStep(2),
        .pMpBaseStep(3)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .kick(kick),
        .done(done),
        .busy(busy),
        .u0_swap(u0_swap),
        .u1_swap(u1_swap),
        .u0_next_itr(u0_next_itr),
        .u1_next_itr(u1_next_itr),
        .u0_swap_ack(u0_swap_ack),
        .u1_swap_ack(u1_swap_ack),
        .u0_next_itr_ack(u0_next_itr_ack),
        .u1_next_itr_ack(u1_next_itr_ack),
        .sh_accu_base(sh_accu_base),
        .mp_accu_init(mp_accu_init),
        .mp_accu_base(mp_accu_base),
        .u0_s_val(u0_s_val),
        .u1_s_val(u1_s_val),
        .fr_s_val(fr_s_val),
        .sel(sel)
    );

    typedef struct {
        int unit;
        int sh;
        int mpi;
        int mpb;
        int cyc;
    } itr_t;

    typedef struct {
        int sel_exp;
        int cyc;
    } swp_t;

    itr_t itr_q[$];
    swp_t swp_q[$];
    int   done_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push_itr(input int unit, input int sh, input int mpi, input int mpb, input int c);
        itr_t e;
        e.unit = unit; e.sh = sh; e.mpi = mpi; e.mpb = mpb; e.cyc = c;
        itr_q.push_back(e);
    endtask

    task automatic push_swp(input int s, input int c);
        swp_t e;
        e.sel_exp = s; e.cyc = c;
        swp_q.push_back(e);
    endtask

    // Monitor: every ack or done the DUT presents must match the head of its queue
    always @(negedge clk) begin
        if (u0_next_itr_ack || u1_next_itr_ack) begin
            itr_t e;
            check("itr_ack_onehot", int'(u0_next_itr_ack & u1_next_itr_ack), 0);
            check("itr_ack_expected", int'(itr_q.size() > 0), 1);
            if (itr_q.size() > 0) begin
                e = itr_q.pop_front();
                check("itr_unit", int'(u1_next_itr_ack), e.unit);
                check("itr_cycle", cyc, e.cyc);
                check("sh_accu_base", int'(sh_accu_base), e.sh);
                check("mp_accu_init", int'(mp_accu_init), e.mpi);
                check("mp_accu_base", int'(mp_accu_base), e.mpb);
            end
        end
        if (u0_swap_ack || u1_swap_ack) begin
            swp_t s;
            check("swap_ack_pair", int'(u0_swap_ack), int'(u1_swap_ack));
            check("swap_ack_expected", int'(swp_q.size() > 0), 1);
            if (swp_q.size() > 0) begin
                s = swp_q.pop_front();
                check("swap_sel", int'(sel), s.sel_exp);
                check("swap_cycle", cyc, s.cyc);
            end
        end
        if (done) begin
            check("done_expected", int'(done_q.size() > 0), 1);
            check("done_busy", int'(busy), 1);
            if (done_q.size() > 0)
                check("done_cycle", cyc, done_q.pop_front());
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; kick = 1'b0;
        u0_swap = 1'b0; u1_swap = 1'b0;
        u0_next_itr = 1'b0; u1_next_itr = 1'b0;
        u0_s_val = 10'h011; u1_s_val = 10'h022;
        repeat (3) tick();
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_sel", int'(sel), 0);
        check("rst_sh", int'(sh_accu_base), 0);
        check("rst_fr", int'(fr_s_val), 0);
        reset_n = 1'b1;
        tick();

        // Sweep 1: parameter sequence from unit 0
        kick = 1'b1; tick(); kick = 1'b0;
        check("busy_after_kick", int'(busy), 1);
        for (int i = 0; i < N; i++) begin
            push_itr(0, i, 2 * i, 3 * i, cyc + 1);
            u0_next_itr = 1'b1; tick();
            u0_next_itr = 1'b0; tick();
        end

        // Fifth request is never acked; a kick while busy changes nothing
        u0_next_itr = 1'b1;
        repeat (3) tick();
        kick = 1'b1; tick(); kick = 1'b0;
        repeat (4) tick();
        check("hold_sh", int'(sh_accu_base), 3);
        check("hold_mpi", int'(mp_accu_init), 6);
        check("hold_mpb", int'(mp_accu_base), 9);
        check("kick_busy", int'(busy), 1);
        u0_next_itr = 1'b0; tick();

        // Swap gating
        u0_swap = 1'b1;
        repeat (10) tick();
        check("gate_fr_u0", int'(fr_s_val), 'h011);
        check("gate_sel", int'(sel), 0);
        push_swp(1, cyc + 1);
        u1_swap = 1'b1; tick();
        check("fr_latency", int'(fr_s_val), 'h011);
        u0_swap = 1'b0; u1_swap = 1'b0; tick();
        check("fr_follow_u1", int'(fr_s_val), 'h022);

        // Remaining swaps complete the sweep
        for (int i = 2; i <= N + 1; i++) begin
            push_swp(i % 2, cyc + 1);
            if (i == N + 1) done_q.push_back(cyc + 2);
            u0_swap = 1'b1; u1_swap = 1'b1; tick();
            u0_swap = 1'b0; u1_swap = 1'b0; tick();
        end
        check("busy_in_done", int'(busy), 1);
        tick();
        check("busy_after_done", int'(busy), 0);
        check("done_cleared", int'(done), 0);
        check("fr_idle", int'(fr_s_val), 0);

        // Sweep 2: simultaneous requests held through the first ack
        kick = 1'b1; tick(); kick = 1'b0;
        push_itr(0, 0, 0, 0, cyc + 1);
        push_itr(1, 1, 2, 3, cyc + 2);
        u0_next_itr = 1'b1; u1_next_itr = 1'b1;
        tick(); tick();
        u0_next_itr = 1'b0; u1_next_itr = 1'b0;
        tick();

        // Coincident swap and parameter grant
        push_itr(0, 2, 4, 6, cyc + 1);
        push_swp(1, cyc + 1);
        u0_next_itr = 1'b1; u0_swap = 1'b1; u1_swap = 1'b1;
        tick();
        u0_next_itr = 1'b0; u0_swap = 1'b0; u1_swap = 1'b0;
        tick();
        check("pre_rst_fr", int'(fr_s_val), 'h022);

        // Asynchronous reset mid-sweep
        reset_n = 1'b0;
        #1;
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_sel", int'(sel), 0);
        check("mid_rst_sh", int'(sh_accu_base), 0);
        check("mid_rst_mpi", int'(mp_accu_init), 0);
        check("mid_rst_mpb", int'(mp_accu_base), 0);
        check("mid_rst_fr", int'(fr_s_val), 0);
        check("mid_rst_done", int'(done), 0);
        tick(); tick();
        reset_n = 1'b1;
        tick();

        // Restart after reset begins from the initial parameters
        kick = 1'b1; tick(); kick = 1'b0;
        push_itr(0, 0, 0, 0, cyc + 1);
        u0_next_itr = 1'b1; tick();
        u0_next_itr = 1'b0; tick();
        tick();

        check("itr_q_drained", itr_q.size(), 0);
        check("swp_q_drained", swp_q.size(), 0);
        check("done_q_drained", done_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
